shift_reg: RTL and testbench
============================

// Module: shift_reg
// PURPOSE
//  - Serial-in / parallel-out plus serial-out shift register of parameterised width.
//  - Captures one data_in bit per enabled clock and presents the full word on data_out.
//  - Provides the oldest bit on serial_out for daisy-chaining further registers.
//  - Used as a generic deserialiser / delay-line building block in the datapath.
// PARAMETERS
//  - WIDTH  default 8  number of register stages; legal range >= 2.
// PORTS
//  - clk         input   1      rising-edge clock; single clock domain.
//  - rst_n       input   1      reset; asynchronous, active-low.
//  - shift_en    input   1      1 = shift this cycle; 0 = hold contents.
//  - data_in     input   1      serial input bit, sampled on rising clk when shift_en=1.
//  - data_out    output  WIDTH  parallel register contents.
//  - serial_out  output  1      serial output, always equal to data_out[WIDTH-1].
// BEHAVIOUR
//  - Storage: one WIDTH-bit register q; data_out = q; serial_out = q[WIDTH-1].
//  - Reset: rst_n=0 clears q to 0 immediately, without waiting for clk.
//    data_out=0 and serial_out=0 while rst_n=0. Release is synchronous to the
//    next rising clk; the first shift can occur on the first edge with rst_n=1.
//  - Shift (rising clk, rst_n=1, shift_en=1): q <= {q[WIDTH-2:0], data_in}.
//    New bits enter at the LSB; the MSB is discarded after being presented on serial_out.
//  - Hold (shift_en=0): q is unchanged. No clock enable gating; shift_en is sampled synchronously.
//  - Latency: a bit on data_in appears at data_out[0] one clock after capture,
//    at data_out[k] after k+1 enabled clocks, and at serial_out after WIDTH enabled clocks.
//  - Outputs are registered; no combinational path from data_in or shift_en to any output.
//  - X/unknown data_in with shift_en=1 propagates as X; no sanitising.
//  - Reset asserted mid-shift: contents are cleared at once; shifting resumes from all-zero after release.
//  - shift_en held high continuously: one bit per clock with no gaps or bubbles.
// TESTING
//  1. Reset: rst_n=0 with arbitrary prior contents -> data_out=8'h00 and serial_out=0
//     before the next clk edge.
//  2. Shift pattern: shift_en=1, data_in 1,0,1,1,0,0,1,0 over 8 clocks -> data_out=8'hB2;
//     serial_out tracks data_out[7] each cycle.
//  3. Hold: after case 2, shift_en=0 for 5 clocks while data_in toggles -> data_out stays 8'hB2.
//  4. Flush: from 8'hB2, shift 8 zeros -> serial_out sequence 1,0,1,1,0,0,1,0
//     (MSB first), then data_out=8'h00.
//  5. Async reset mid-run: assert rst_n=0 between clock edges during continuous shifting
//     -> outputs zero immediately; after release, one shift of 1 -> data_out=8'h01.
//  6. Random: 9-bit random bursts with shift_en=1, repeated 10 times; a reference model
//     must match data_out each cycle, also for WIDTH=4 and WIDTH=16 builds.

Source files
------------

// File: rtl/shift_reg.sv
// -----------------------------------------------------------------------------
// shift_reg
//
// Serial-in / parallel-out shift register that also has a serial output.
// Each enabled clock captures one data_in bit at the LSB. The full word is
// presented on data_out. The oldest bit (MSB) is presented on serial_out so
// that further registers can be daisy-chained. The block serves as a generic
// deserialiser or delay line.
//
// Parameters
//   WIDTH       number of register stages (>= 2), default 8
//
// Ports
//   clk         input   1      rising-edge clock
//   rst_n       input   1      asynchronous active-low reset, clears contents
//   shift_en    input   1      1 = shift this cycle, 0 = hold contents
//   data_in     input   1      serial input bit, sampled when shift_en=1
//   data_out    output  WIDTH  parallel register contents
//   serial_out  output  1      oldest bit, always data_out[WIDTH-1]
//
// Both outputs come straight from the storage flops. There is no
// combinational path from data_in or shift_en to either output.
// -----------------------------------------------------------------------------
module shift_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             shift_en,
    input  logic             data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             serial_out
);

    logic [WIDTH-1:0] q;

    // Reset clears the register immediately. shift_en is an ordinary
    // synchronous enable and does not gate the clock. An X on data_in is
    // shifted in unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (shift_en) begin
            q <= {q[WIDTH-2:0], data_in};
        end
    end

    assign data_out   = q;
    assign serial_out = q[WIDTH-1];

endmodule

// File: tb/tb_shift_reg.sv
// -----------------------------------------------------------------------------
// tb_shift_reg
//
// Self-checking bench for shift_reg. Three instances (WIDTH 8, 4 and 16)
// share the same stimulus. Directed tests run against the 8-bit instance.
// A random test checks all three instances against simple reference shift
// models.
// -----------------------------------------------------------------------------
module tb_shift_reg;

    logic        clk;
    logic        rst_n;
    logic        shift_en;
    logic        data_in;
    logic [7:0]  data_out8;
    logic        serial_out8;
    logic [3:0]  data_out4;
    logic        serial_out4;
    logic [15:0] data_out16;
    logic        serial_out16;

    // reference models, one per instance width
    logic [7:0]  m8;
    logic [3:0]  m4;
    logic [15:0] m16;

    // expected serial_out sequence for the flush test
    logic [0:0]  exp_q[$];

    int checks;
    int failures;

    shift_reg #(.WIDTH(8)) dut8 (
        .clk        (clk),
        .rst_n      (rst_n),
        .shift_en   (shift_en),
        .data_in    (data_in),
        .data_out   (data_out8),
        .serial_out (serial_out8)
    );

    shift_reg #(.WIDTH(4)) dut4 (
        .clk        (clk),
        .rst_n      (rst_n),
        .shift_en   (shift_en),
        .data_in    (data_in),
        .data_out   (data_out4),
        .serial_out (serial_out4)
    );

    shift_reg #(.WIDTH(16)) dut16 (
        .clk        (clk),
        .rst_n      (rst_n),
        .shift_en   (shift_en),
        .data_in    (data_in),
        .data_out   (data_out16),
        .serial_out (serial_out16)
    );

    // ---------------------------------------------------------------- clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ------------------------------------------------------------- watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog expired");
    end

    // -------------------------------------------------------------- drivers
    // Applies one clock with the given inputs and samples 1ns after the edge.
    // The models advance exactly as the specification describes a shift.
    task automatic step(input logic en, input logic din);
        shift_en = en;
        data_in  = din;
        @(posedge clk);
        if (rst_n && en) begin
            m8  = {m8[6:0], din};
            m4  = {m4[2:0], din};
            m16 = {m16[14:0], din};
        end
        #1;
    endtask

    // Synchronous-looking reset pulse placed between edges.
    task automatic pulse_reset();
        shift_en = 1'b0;
        data_in  = 1'b0;
        #2;
        rst_n = 1'b0;
        m8  = '0;
        m4  = '0;
        m16 = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // ---------------------------------------------------------------- tests
    task automatic test_reset();
        // Load arbitrary contents, then assert reset between edges.
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1);
        checks++;
        if (data_out8 !== 8'h1F) begin
            failures++;
            $display("FAIL reset_preload: data_out=%h required=%h", data_out8, 8'h1F);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (data_out8 !== 8'h00) begin
            failures++;
            $display("FAIL reset_async_data: data_out=%h required=%h", data_out8, 8'h00);
        end
        checks++;
        if (serial_out8 !== 1'b0) begin
            failures++;
            $display("FAIL reset_async_serial: serial_out=%b required=0", serial_out8);
        end
        checks++;
        if (data_out4 !== 4'h0 || data_out16 !== 16'h0000) begin
            failures++;
            $display("FAIL reset_other_widths: data_out4=%h data_out16=%h required=0", data_out4, data_out16);
        end
        // Held reset ignores enabled clocks.
        step(1'b1, 1'b1);
        checks++;
        if (data_out8 !== 8'h00) begin
            failures++;
            $display("FAIL reset_held: data_out=%h required=%h", data_out8, 8'h00);
        end
        rst_n = 1'b1;
        m8  = '0;
        m4  = '0;
        m16 = '0;
    endtask

    task automatic test_shift_pattern();
        logic [7:0] bits;
        logic [7:0] exp_words [8];
        bits = 8'b1011_0010;
        exp_words = '{8'h01, 8'h02, 8'h05, 8'h0B, 8'h16, 8'h2C, 8'h59, 8'hB2};
        for (int i = 0; i < 8; i++) begin
            step(1'b1, bits[7-i]);
            checks++;
            if (data_out8 !== exp_words[i]) begin
                failures++;
                $display("FAIL shift_word[%0d]: data_out=%h required=%h", i, data_out8, exp_words[i]);
            end
            checks++;
            if (serial_out8 !== exp_words[i][7]) begin
                failures++;
                $display("FAIL shift_serial[%0d]: serial_out=%b required=%b", i, serial_out8, exp_words[i][7]);
            end
        end
    endtask

    task automatic test_hold();
        for (int i = 0; i < 5; i++) begin
            step(1'b0, i[0]);
            checks++;
            if (data_out8 !== 8'hB2 || serial_out8 !== 1'b1) begin
                failures++;
                $display("FAIL hold[%0d]: data_out=%h serial_out=%b required=b2/1", i, data_out8, serial_out8);
            end
        end
    endtask

    task automatic test_flush();
        logic [0:0] exp_bit;
        exp_q = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 8; i++) begin
            exp_bit = exp_q.pop_front();
            checks++;
            if (serial_out8 !== exp_bit[0]) begin
                failures++;
                $display("FAIL flush_serial[%0d]: serial_out=%b required=%b", i, serial_out8, exp_bit[0]);
            end
            step(1'b1, 1'b0);
        end
        checks++;
        if (data_out8 !== 8'h00 || serial_out8 !== 1'b0) begin
            failures++;
            $display("FAIL flush_final: data_out=%h serial_out=%b required=00/0", data_out8, serial_out8);
        end
    endtask

    task automatic test_async_reset_mid_run();
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
        checks++;
        if (data_out8 !== 8'h07) begin
            failures++;
            $display("FAIL midrun_preload: data_out=%h required=%h", data_out8, 8'h07);
        end
        // shifting continues; reset lands between edges
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (data_out8 !== 8'h00 || serial_out8 !== 1'b0) begin
            failures++;
            $display("FAIL midrun_async: data_out=%h serial_out=%b required=00/0", data_out8, serial_out8);
        end
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        m8  = '0;
        m4  = '0;
        m16 = '0;
        step(1'b1, 1'b1);
        checks++;
        if (data_out8 !== 8'h01) begin
            failures++;
            $display("FAIL midrun_release: data_out=%h required=%h", data_out8, 8'h01);
        end
        step(1'b0, 1'b0);
    endtask

    task automatic test_random();
        logic din;
        pulse_reset();
        for (int b = 0; b < 10; b++) begin
            for (int i = 0; i < 9; i++) begin
                din = 1'($urandom_range(0, 1));
                step(1'b1, din);
                checks++;
                if (data_out8 !== m8 || data_out4 !== m4 || data_out16 !== m16) begin
                    failures++;
                    $display("FAIL random[%0d.%0d]: got %h/%h/%h required %h/%h/%h",
                             b, i, data_out8, data_out4, data_out16, m8, m4, m16);
                end
                checks++;
                if (serial_out8 !== m8[7] || serial_out4 !== m4[3] || serial_out16 !== m16[15]) begin
                    failures++;
                    $display("FAIL random_serial[%0d.%0d]: got %b/%b/%b required %b/%b/%b",
                             b, i, serial_out8, serial_out4, serial_out16, m8[7], m4[3], m16[15]);
                end
            end
            // idle gap with toggling data between bursts
            step(1'b0, 1'($urandom_range(0, 1)));
            checks++;
            if (data_out8 !== m8 || data_out4 !== m4 || data_out16 !== m16) begin
                failures++;
                $display("FAIL random_gap[%0d]: got %h/%h/%h required %h/%h/%h",
                         b, data_out8, data_out4, data_out16, m8, m4, m16);
            end
        end
    endtask

    // ----------------------------------------------------------- main flow
    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        shift_en = 1'b0;
        data_in  = 1'b0;
        m8       = '0;
        m4       = '0;
        m16      = '0;
        #1;
        checks++;
        if (data_out8 !== 8'h00 || serial_out8 !== 1'b0) begin
            failures++;
            $display("FAIL initial_reset: data_out=%h serial_out=%b required=00/0", data_out8, serial_out8);
        end
        @(posedge clk);
        #1;

        test_reset();
        test_shift_pattern();
        test_hold();
        test_flush();
        test_async_reset_mid_run();
        test_random();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
